seg_scan_capture: RTL and testbench

//  Receiving end of the multiplexed 7-segment bus (4-bit digit enables + 7-bit segments) driven by the display controller.

---
 rtl/seg_scan_pkg.sv | 28 ++
 rtl/seg7_pattern_decode.sv | 28 ++
 rtl/seg_scan_capture.sv | 206 ++++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared symbol codes, scan FSM states and 7-segment patterns for the scan-capture block.
package seg_scan_pkg;

    localparam logic [4:0] CODE_BLANK = 5'h10;
    localparam logic [4:0] CODE_R     = 5'h11;
    localparam logic [4:0] CODE_O     = 5'h12;
    localparam logic [4:0] CODE_DASH  = 5'h13;
    localparam logic [4:0] CODE_UNK   = 5'h1F;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } scan_state_t;

    // Lit-segment patterns, gfedcba, active-high.
    localparam logic [6:0] PAT_BLANK = 7'h00;
    localparam logic [6:0] PAT_R     = 7'h50;
    localparam logic [6:0] PAT_O     = 7'h5C;
    localparam logic [6:0] PAT_DASH  = 7'h40;

    // Element i is the pattern for hex digit i.
    localparam logic [15:0][6:0] HEX_PAT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment decode: active-low segment pattern to 5-bit symbol code.
module seg7_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [4:0] code
);

    logic [6:0] lit;
    assign lit = ~seg_n;

    always_comb begin
        code = CODE_UNK;
        case (lit)
            PAT_BLANK: code = CODE_BLANK;
            PAT_R:     code = CODE_R;
            PAT_O:     code = CODE_O;
            PAT_DASH:  code = CODE_DASH;
            default:   ;
        endcase
        for (int i = 0; i < 16; i++) begin
            if (lit == HEX_PAT[i]) begin
                code = 5'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a scanned 4-digit 7-segment bus back into symbol frames on a valid/ready port.
// Optional: define SEG_SCAN_CHANGE_ONLY_EN to suppress frames identical to the last one emitted.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic        clk0,
    input  logic        rst_n,
    input  logic [3:0]  digitos,
    input  logic [6:0]  segments,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [19:0] frame_data,
    output logic        overflow,
    output logic [7:0]  glitch_cnt,
    output logic        scan_stall
);

    localparam int              SW        = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]   TIMEOUT_C = SW'(TIMEOUT);
    localparam logic [3:0]      SETTLE_C  = 4'(SETTLE);

    logic [3:0]    dig_s1_reg, dig_s2_reg, dig_prev_reg;
    logic [6:0]    seg_s1_reg, seg_s2_reg;
    logic [7:0]    glitch_cnt_reg;
    logic [SW-1:0] stall_cnt_reg;
    scan_state_t   state_reg, state_next;
    logic [3:0]    settle_reg, settle_next;
    logic [1:0]    cur_idx_reg, cur_idx_next;
    logic [3:0]    seen_reg, seen_next;
    logic [19:0]   frame_new, shadow_reg, frame_data_reg;
    logic          frame_valid_reg, pending_reg, overflow_reg;
    logic          one_hot, glitch, capture, complete_raw, complete, accept;
    logic [1:0]    idx_now;
    logic [4:0]    code_now;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            dig_s1_reg   <= 4'hF;
            dig_s2_reg   <= 4'hF;
            dig_prev_reg <= 4'hF;
            seg_s1_reg   <= 7'h7F;
            seg_s2_reg   <= 7'h7F;
        end else begin
            dig_s1_reg   <= digitos;
            dig_s2_reg   <= dig_s1_reg;
            dig_prev_reg <= dig_s2_reg;
            seg_s1_reg   <= segments;
            seg_s2_reg   <= seg_s1_reg;
        end
    end

    always_comb begin
        one_hot = 1'b1;
        idx_now = 2'd0;
        case (dig_s2_reg)
            4'b1110: idx_now = 2'd0;
            4'b1101: idx_now = 2'd1;
            4'b1011: idx_now = 2'd2;
            4'b0111: idx_now = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    // Multi-low enables count as glitches and are otherwise treated as blanking.
    assign glitch = !one_hot && (dig_s2_reg != 4'hF);

    always_comb begin
        state_next   = state_reg;
        settle_next  = settle_reg;
        cur_idx_next = cur_idx_reg;
        capture      = 1'b0;
        case (state_reg)
            S_WAIT: begin
                if (one_hot) begin
                    cur_idx_next = idx_now;
                    settle_next  = 4'd1;
                    if (SETTLE == 1) begin
                        capture    = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        state_next = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (!one_hot || idx_now != cur_idx_reg) begin
                    state_next = S_WAIT;
                end else begin
                    settle_next = settle_reg + 4'd1;
                    if (settle_reg + 4'd1 == SETTLE_C) begin
                        capture    = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!one_hot || idx_now != cur_idx_reg) begin
                    state_next = S_WAIT;
                end
            end
            default: state_next = S_WAIT;
        endcase
    end

    seg7_pattern_decode u_decode (
        .seg_n (seg_s2_reg),
        .code  (code_now)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [4:0] slot_reg;
            logic       hit;
            assign hit = capture && (idx_now == 2'(gi));
            assign frame_new[gi*5 +: 5] = hit ? code_now : slot_reg;
            always_ff @(posedge clk0 or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (hit) begin
                    slot_reg <= code_now;
                end
            end
        end
    endgenerate

    assign complete_raw = capture && ((seen_reg | ~dig_s2_reg) == 4'hF);
    assign seen_next    = complete_raw ? 4'h0 : (capture ? (seen_reg | ~dig_s2_reg) : seen_reg);

`ifdef SEG_SCAN_CHANGE_ONLY_EN
    logic emitted_reg;
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            emitted_reg <= 1'b0;
        end else if (complete) begin
            emitted_reg <= 1'b1;
        end
    end
    assign complete = complete_raw && !(emitted_reg && (frame_new == frame_data_reg));
`else
    assign complete = complete_raw;
`endif

    assign accept = frame_valid_reg && frame_ready;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_WAIT;
            settle_reg      <= 4'd0;
            cur_idx_reg     <= 2'd0;
            seen_reg        <= 4'h0;
            glitch_cnt_reg  <= 8'd0;
            stall_cnt_reg   <= '0;
            shadow_reg      <= '0;
            frame_data_reg  <= '0;
            frame_valid_reg <= 1'b0;
            pending_reg     <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            settle_reg  <= settle_next;
            cur_idx_reg <= cur_idx_next;
            seen_reg    <= seen_next;
            if (glitch && glitch_cnt_reg != 8'hFF) begin
                glitch_cnt_reg <= glitch_cnt_reg + 8'd1;
            end
            if (dig_s2_reg != dig_prev_reg) begin
                stall_cnt_reg <= '0;
            end else if (stall_cnt_reg != TIMEOUT_C) begin
                stall_cnt_reg <= stall_cnt_reg + SW'(1);
            end
            if (complete) begin
                shadow_reg <= frame_new;
                if (pending_reg && accept) begin
                    // Older pending frame goes out first; the new one stays pending.
                    frame_data_reg <= shadow_reg;
                end else if (!frame_valid_reg || accept) begin
                    frame_data_reg  <= frame_new;
                    frame_valid_reg <= 1'b1;
                end else begin
                    pending_reg <= 1'b1;
                    if (pending_reg) begin
                        overflow_reg <= 1'b1;
                    end
                end
            end else if (accept) begin
                if (pending_reg) begin
                    frame_data_reg <= shadow_reg;
                    pending_reg    <= 1'b0;
                end else begin
                    frame_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign frame_valid = frame_valid_reg;
    assign frame_data  = frame_data_reg;
    assign overflow    = overflow_reg;
    assign glitch_cnt  = glitch_cnt_reg;
    assign scan_stall  = (stall_cnt_reg == TIMEOUT_C);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans frames onto the bus and scoreboards emitted frames.
module tb_seg_scan_capture;

    logic        clk0 = 1'b0;
    logic        rst_n;
    logic [3:0]  digitos;
    logic [6:0]  segments;
    logic        frame_ready;
    logic        frame_valid;
    logic [19:0] frame_data;
    logic        overflow;
    logic [7:0]  glitch_cnt;
    logic        scan_stall;

    int tests_run    = 0;
    int tests_failed = 0;
    int hs_count     = 0;
    int hs_before    = 0;
    logic [19:0] exp_q[$];

    seg_scan_capture #(.SETTLE(3), .TIMEOUT(400)) dut (
        .clk0        (clk0),
        .rst_n       (rst_n),
        .digitos     (digitos),
        .segments    (segments),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .overflow    (overflow),
        .glitch_cnt  (glitch_cnt),
        .scan_stall  (scan_stall)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk0);
            #1;
        end
    endtask

    // Active-low segment drive for a symbol code, independent of the DUT tables.
    function automatic logic [6:0] seg_lo(input logic [4:0] c);
        logic [6:0] p;
        case (c)
            5'h00: p = 7'h3F; 5'h01: p = 7'h06; 5'h02: p = 7'h5B; 5'h03: p = 7'h4F;
            5'h04: p = 7'h66; 5'h05: p = 7'h6D; 5'h06: p = 7'h7D; 5'h07: p = 7'h07;
            5'h08: p = 7'h7F; 5'h09: p = 7'h6F; 5'h0A: p = 7'h77; 5'h0B: p = 7'h7C;
            5'h0C: p = 7'h39; 5'h0D: p = 7'h5E; 5'h0E: p = 7'h79; 5'h0F: p = 7'h71;
            5'h10: p = 7'h00; 5'h11: p = 7'h50; 5'h12: p = 7'h5C; 5'h13: p = 7'h40;
            default: p = 7'h7E;
        endcase
        return ~p;
    endfunction

    function automatic logic [19:0] mk(input logic [4:0] c3, input logic [4:0] c2,
                                       input logic [4:0] c1, input logic [4:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic scan(input logic [19:0] f, input bit expect_out, input int hold);
        logic [3:0] en;
        if (expect_out) exp_q.push_back(f);
        for (int d = 0; d < 4; d++) begin
            en       = 4'b0001 << d;
            digitos  = ~en;
            segments = seg_lo(f[d*5 +: 5]);
            tick(hold);
        end
    endtask

    task automatic blank(input int n);
        digitos  = 4'hF;
        segments = 7'h7F;
        tick(n);
    endtask

    // Scoreboard: every handshake must match the oldest expected frame.
    always @(negedge clk0) begin
        logic [31:0] exp_v;
        if (rst_n && frame_valid && frame_ready) begin
            hs_count++;
            exp_v = (exp_q.size() != 0) ? {12'h0, exp_q.pop_front()} : 32'hDEAD0000;
            check("frame_data", {12'h0, frame_data}, exp_v);
            $display("[TB] handshake %0d frame_data=0x%05h", hs_count, frame_data);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        digitos     = 4'hF;
        segments    = 7'h7F;
        frame_ready = 1'b0;
        tick(3);
        check("rst_valid", frame_valid, 0);
        check("rst_data", frame_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_glitch", glitch_cnt, 0);
        check("rst_stall", scan_stall, 0);
        rst_n = 1'b1;
        tick(2);

        // Basic scan 1,2,3,4
        frame_ready = 1'b1;
        scan(mk(5'h04, 5'h03, 5'h02, 5'h01), 1, 8);
        blank(6);
        check("t1_handshakes", hs_count, 1);
        check("t1_glitch", glitch_cnt, 0);

        // Enable pulses shorter than SETTLE capture nothing
        for (int r = 0; r < 3; r++) begin
            scan(mk(5'h05, 5'h05, 5'h05, 5'h05), 0, 2);
        end
        blank(6);
        check("t2_short_hs", hs_count, 1);
        check("t2_short_valid", frame_valid, 0);
        scan(mk(5'h0D, 5'h0C, 5'h0B, 5'h0A), 1, 8);
        blank(6);
        check("t2_after_hs", hs_count, 2);

        // Special symbols and unknown pattern
        scan(mk(5'h1F, 5'h13, 5'h11, 5'h10), 1, 8);
        scan(mk(5'h0F, 5'h08, 5'h00, 5'h12), 1, 8);
        blank(6);
        check("t2_special_hs", hs_count, 4);

        // Multi-low enables saturate the glitch counter
        digitos = 4'b0011;
        tick(300);
        check("t3_glitch_sat", glitch_cnt, 255);
        check("t3_valid", frame_valid, 0);
        blank(4);
        check("t3_hs", hs_count, 4);

        // Back-pressure over three frames: first held, second overwritten by third
        frame_ready = 1'b0;
        scan(mk(5'h0E, 5'h0E, 5'h00, 5'h01), 1, 8);
        scan(mk(5'h02, 5'h02, 5'h02, 5'h02), 0, 8);
        scan(mk(5'h03, 5'h03, 5'h13, 5'h13), 1, 8);
        blank(6);
        check("t4_valid_held", frame_valid, 1);
        check("t4_data_held", frame_data, mk(5'h0E, 5'h0E, 5'h00, 5'h01));
        check("t4_overflow", overflow, 1);
        frame_ready = 1'b1;
        tick(6);
        check("t4_valid_drained", frame_valid, 0);
        check("t4_hs", hs_count, 6);

        // Scan stall
        digitos = 4'b1101;
        tick(1);
        blank(350);
        check("t5_stall_early", scan_stall, 0);
        for (int i = 0; i < 100 && !scan_stall; i++) tick(1);
        check("t5_stall_set", scan_stall, 1);
        digitos = 4'b1110;
        tick(2);
        blank(4);
        check("t5_stall_clear", scan_stall, 0);

        // Identical frame three times
        hs_before = hs_count;
        for (int r = 0; r < 3; r++) begin
`ifdef SEG_SCAN_CHANGE_ONLY_EN
            scan(mk(5'h09, 5'h08, 5'h07, 5'h06), (r == 0), 8);
`else
            scan(mk(5'h09, 5'h08, 5'h07, 5'h06), 1, 8);
`endif
        end
        blank(6);
`ifdef SEG_SCAN_CHANGE_ONLY_EN
        check("t6_repeat_hs", hs_count - hs_before, 1);
`else
        check("t6_repeat_hs", hs_count - hs_before, 3);
`endif

        // Reset mid-scan with a held frame and partial slots
        frame_ready = 1'b0;
        scan(mk(5'h0A, 5'h0B, 5'h01, 5'h02), 0, 8);
        digitos  = 4'b1110;
        segments = seg_lo(5'h07);
        tick(8);
        digitos = 4'b1101;
        tick(8);
        check("t7_valid_before", frame_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", frame_valid, 0);
        check("t7_rst_data", frame_data, 0);
        check("t7_rst_overflow", overflow, 0);
        check("t7_rst_glitch", glitch_cnt, 0);
        tick(2);
        rst_n       = 1'b1;
        frame_ready = 1'b1;
        tick(2);
        scan(mk(5'h0C, 5'h00, 5'h0F, 5'h0E), 1, 8);
        blank(6);
        check("t7_post_rst_valid", frame_valid, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
